// File: rtl/hash_byte_sequencer.sv
// hash_byte_sequencer: control FSM for the byte-serial S-box hash core.
// Accepts message bytes on a valid/ready handshake and issues ROUNDS round strobes per byte.
// It keeps the byte counter and issues the finalisation strobe with that count after the last byte.
// It then registers the digest and pulses hash_ready.
// Ports: clk, rst_n (async active-low); msg_valid/msg_byte/msg_last/msg_ready upstream;
//   core_init/core_byte/core_round/core_round_idx/core_final/core_count/core_digest core side;
//   digest_out, hash_ready, busy status.
// Optional: define HASH_SEQ_ABORT_EN to add the abort input.
module hash_byte_sequencer #(
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned CNT_W  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef HASH_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             msg_valid,
  input  logic [7:0]       msg_byte,
  input  logic             msg_last,
  output logic             msg_ready,
  output logic             core_init,
  output logic [7:0]       core_byte,
  output logic             core_round,
  output logic [3:0]       core_round_idx,
  output logic             core_final,
  output logic [CNT_W-1:0] core_count,
  input  logic [31:0]      core_digest,
  output logic [31:0]      digest_out,
  output logic             hash_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic [31:0]      dig_q, dig_d;
  logic             accept;

`ifdef HASH_SEQ_ABORT_EN
  // abort wins over a same-cycle accept
  assign msg_ready = (state_q == IDLE) && !abort;
`else
  assign msg_ready = (state_q == IDLE);
`endif

  assign accept = msg_valid && msg_ready;

  // IV load happens in the accept cycle itself
  assign core_init = accept && first_q;

  assign core_byte      = byte_q;
  assign core_round     = (state_q == ROUND);
  assign core_round_idx = idx_q;
  assign core_final     = (state_q == FINAL);
  assign core_count     = cnt_q;
  assign digest_out     = dig_q;
  assign hash_ready     = (state_q == DONE);
  assign busy           = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    first_d = first_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          byte_d  = msg_byte;
          cnt_d   = cnt_q + CNT_W'(1);
          last_d  = msg_last;
          idx_d   = 4'd0;
          first_d = 1'b0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (idx_q == LAST_IDX) begin
          state_d = last_q ? FINAL : IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      FINAL: begin
        dig_d   = core_digest;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        first_d = 1'b1;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef HASH_SEQ_ABORT_EN
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 4'd0;
      last_d  = 1'b0;
      first_d = 1'b1;
      dig_d   = dig_q;
      byte_d  = byte_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= 8'd0;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
      dig_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      first_q <= first_d;
      dig_q   <= dig_d;
    end
  end

endmodule

// File: tb/tb_hash_byte_sequencer.sv
// tb_hash_byte_sequencer: self-checking bench for hash_byte_sequencer.
// Expected timing is computed from cycles elapsed since each accept.
module tb_hash_byte_sequencer;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msg_valid;
  logic [7:0]  msg_byte;
  logic        msg_last;
  logic        msg_ready;
  logic        core_init;
  logic [7:0]  core_byte;
  logic        core_round;
  logic [3:0]  core_round_idx;
  logic        core_final;
  logic [63:0] core_count;
  logic [31:0] core_digest;
  logic [31:0] digest_out;
  logic        hash_ready;
  logic        busy;
`ifdef HASH_SEQ_ABORT_EN
  logic        abort;
`endif

  int          errs = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] exp_cnt;
  logic [31:0] last_dig;

  hash_byte_sequencer #(.ROUNDS(R), .CNT_W(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef HASH_SEQ_ABORT_EN
    .abort          (abort),
`endif
    .msg_valid      (msg_valid),
    .msg_byte       (msg_byte),
    .msg_last       (msg_last),
    .msg_ready      (msg_ready),
    .core_init      (core_init),
    .core_byte      (core_byte),
    .core_round     (core_round),
    .core_round_idx (core_round_idx),
    .core_final     (core_final),
    .core_count     (core_count),
    .core_digest    (core_digest),
    .digest_out     (digest_out),
    .hash_ready     (hash_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one message starting in IDLE; gap[i] idle cycles precede byte i.
  // gap 0 on a later byte means valid stays high through the previous rounds.
  task automatic send_msg(input string nm, input logic [7:0] b [4],
                          input int n, input int gap [4],
                          input logic [31:0] dig, output int acc [4]);
    core_digest = dig;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        msg_valid = 1'b0;
        #1;
        checks++;
        if (msg_ready !== 1'b1 || core_init !== 1'b0 || busy !== 1'b0) begin
          errs++;
          $display("FAIL %s idle: ready=%b init=%b busy=%b, want 1 0 0",
                   nm, msg_ready, core_init, busy);
        end
        @(negedge clk);
      end
      msg_valid = 1'b1;
      msg_byte  = b[i];
      msg_last  = (i == n - 1);
      #1;
      checks++;
      if (msg_ready !== 1'b1 || core_init !== (i == 0)) begin
        errs++;
        $display("FAIL %s accept%0d: ready=%b init=%b, want 1 %b",
                 nm, i, msg_ready, core_init, (i == 0));
      end
      acc[i] = cyc;
      @(negedge clk);
      exp_cnt = exp_cnt + 64'd1;
      if (i < n - 1 && gap[i+1] == 0) begin
        msg_byte = b[i+1];
        msg_last = (i + 1 == n - 1);
      end else begin
        msg_valid = 1'b0;
      end
      for (int k = 1; k <= R; k++) begin
        #1;
        checks++;
        if (core_round !== 1'b1 || core_round_idx !== 4'(k - 1) ||
            core_byte !== b[i] || msg_ready !== 1'b0 || busy !== 1'b1 ||
            core_init !== 1'b0 || core_final !== 1'b0) begin
          errs++;
          $display("FAIL %s round%0d.%0d: rnd=%b idx=%0d byte=%h rdy=%b busy=%b init=%b fin=%b, want 1 %0d %h 0 1 0 0",
                   nm, i, k, core_round, core_round_idx, core_byte, msg_ready,
                   busy, core_init, core_final, k - 1, b[i]);
        end
        @(negedge clk);
      end
      if (i == n - 1) begin
        msg_valid = 1'b0;
        #1;
        checks++;
        if (core_final !== 1'b1 || core_count !== exp_cnt ||
            core_round !== 1'b0 || msg_ready !== 1'b0 || hash_ready !== 1'b0) begin
          errs++;
          $display("FAIL %s final: fin=%b cnt=%h rnd=%b rdy=%b hr=%b, want 1 %h 0 0 0",
                   nm, core_final, core_count, core_round, msg_ready, hash_ready, exp_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hash_ready !== 1'b1 || digest_out !== dig || core_final !== 1'b0 ||
            busy !== 1'b1 || msg_ready !== 1'b0) begin
          errs++;
          $display("FAIL %s done: hr=%b dig=%h fin=%b busy=%b rdy=%b, want 1 %h 0 1 0",
                   nm, hash_ready, digest_out, core_final, busy, msg_ready, dig);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hash_ready !== 1'b0 || busy !== 1'b0 || msg_ready !== 1'b1 ||
            digest_out !== dig) begin
          errs++;
          $display("FAIL %s after: hr=%b busy=%b rdy=%b dig=%h, want 0 0 1 %h",
                   nm, hash_ready, busy, msg_ready, digest_out, dig);
        end
        exp_cnt  = 64'd0;
        last_dig = dig;
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    msg_valid   = 1'b0;
    msg_byte    = 8'd0;
    msg_last    = 1'b0;
    core_digest = 32'd0;
    exp_cnt     = 64'd0;
    last_dig    = 32'd0;
`ifdef HASH_SEQ_ABORT_EN
    abort       = 1'b0;
`endif
    #3;
    checks++;
    if (msg_ready !== 1'b1 || core_init !== 1'b0 || core_round !== 1'b0 ||
        core_final !== 1'b0 || core_byte !== 8'd0 || core_round_idx !== 4'd0 ||
        core_count !== 64'd0 || digest_out !== 32'd0 || hash_ready !== 1'b0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL reset: rdy=%b init=%b rnd=%b fin=%b byte=%h idx=%0d cnt=%h dig=%h hr=%b busy=%b, want 1 0 0 0 00 0 0 0 0 0",
               msg_ready, core_init, core_round, core_final, core_byte,
               core_round_idx, core_count, digest_out, hash_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b [4];
    int         gp [4];
    int         acc [4];
    b  = '{8'h41, 8'h00, 8'h00, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("single", b, 1, gp, 32'hDEADBEEF, acc);
  endtask

  task automatic test_multi();
    logic [7:0] b [4];
    int         gp [4];
    int         acc [4];
    b  = '{8'h61, 8'h62, 8'h63, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("multi", b, 3, gp, 32'h12345678, acc);
    checks++;
    if (acc[1] - acc[0] !== R + 1 || acc[2] - acc[0] !== 2 * (R + 1)) begin
      errs++;
      $display("FAIL multi spacing: %0d %0d, want %0d %0d",
               acc[1] - acc[0], acc[2] - acc[0], R + 1, 2 * (R + 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    int         gp [4];
    int         a1 [4];
    int         a2 [4];
    b  = '{8'h11, 8'h00, 8'h00, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("b2b_1", b, 1, gp, 32'hA5A5_0001, a1);
    b  = '{8'h22, 8'h00, 8'h00, 8'h00};
    gp = '{1, 0, 0, 0};
    send_msg("b2b_2", b, 1, gp, 32'hA5A5_0002, a2);
    checks++;
    if (a2[0] - a1[0] !== R + 4) begin
      errs++;
      $display("FAIL b2b spacing: %0d, want %0d", a2[0] - a1[0], R + 4);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b [4];
    int         gp [4];
    int         acc [4];
    msg_valid = 1'b1;
    msg_byte  = 8'h5A;
    msg_last  = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (msg_ready !== 1'b1 || core_round !== 1'b0 || core_final !== 1'b0 ||
        core_byte !== 8'd0 || core_round_idx !== 4'd0 || core_count !== 64'd0 ||
        digest_out !== 32'd0 || hash_ready !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: rdy=%b rnd=%b fin=%b byte=%h idx=%0d cnt=%h dig=%h hr=%b busy=%b, want 1 0 0 00 0 0 0 0 0",
               msg_ready, core_round, core_final, core_byte, core_round_idx,
               core_count, digest_out, hash_ready, busy);
    end
    exp_cnt  = 64'd0;
    last_dig = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < R + 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (hash_ready !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL reset_mid quiet%0d: hr=%b busy=%b, want 0 0",
                 k, hash_ready, busy);
      end
    end
    b  = '{8'h77, 8'h00, 8'h00, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("reset_mid_new", b, 1, gp, 32'hCAFE_F00D, acc);
  endtask

  task automatic test_wrap();
    logic [7:0] b [4];
    int         gp [4];
    int         acc [4];
    @(negedge clk);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    b  = '{8'hFE, 8'h00, 8'h00, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("wrap", b, 1, gp, 32'h0BAD_CAFE, acc);
  endtask

  task automatic test_random();
    logic [7:0]  b [4];
    int          gp [4];
    int          acc [4];
    int          n;
    logic [31:0] dig;
    for (int m = 0; m < 6; m++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        b[i]  = 8'($urandom);
        gp[i] = $urandom_range(0, 3);
      end
      dig = $urandom;
      send_msg("random", b, n, gp, dig, acc);
    end
  endtask

`ifdef HASH_SEQ_ABORT_EN
  task automatic test_abort();
    logic [7:0] b [4];
    int         gp [4];
    int         acc [4];
    msg_valid = 1'b1;
    msg_byte  = 8'h31;
    msg_last  = 1'b0;
    @(negedge clk);
    msg_byte = 8'h32;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    abort     = 1'b1;
    msg_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || msg_ready !== 1'b1 || core_round !== 1'b0 ||
        core_round_idx !== 4'd0 || core_count !== 64'd0 || digest_out !== last_dig) begin
      errs++;
      $display("FAIL abort idle: busy=%b rdy=%b rnd=%b idx=%0d cnt=%h dig=%h, want 0 1 0 0 0 %h",
               busy, msg_ready, core_round, core_round_idx, core_count,
               digest_out, last_dig);
    end
    abort     = 1'b1;
    msg_valid = 1'b1;
    msg_byte  = 8'h99;
    msg_last  = 1'b1;
    #1;
    checks++;
    if (msg_ready !== 1'b0 || core_init !== 1'b0) begin
      errs++;
      $display("FAIL abort prio: rdy=%b init=%b, want 0 0", msg_ready, core_init);
    end
    @(negedge clk);
    abort     = 1'b0;
    msg_valid = 1'b0;
    for (int k = 0; k < R + 3; k++) begin
      #1;
      checks++;
      if (hash_ready !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL abort quiet%0d: hr=%b busy=%b, want 0 0", k, hash_ready, busy);
      end
      @(negedge clk);
    end
    exp_cnt = 64'd0;
    b  = '{8'h44, 8'h00, 8'h00, 8'h00};
    gp = '{0, 0, 0, 0};
    send_msg("abort_next", b, 1, gp, 32'h600D_600D, acc);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
`ifdef HASH_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

endmodule
